// File: rtl/imem_loader_if.sv
// Bus between the UART byte source / control side and the instruction-memory loader.
// The loader takes the slave modport; whatever feeds bytes and watches the write port takes master.
`timescale 1ns/1ps
interface imem_loader_if #(
  parameter int ADDR_W = 14
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              start;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic              cpu_hold;

  modport slave (
    input  rx_data, rx_valid, start,
    output imem_we, imem_waddr, imem_wdata, busy, done, err, cpu_hold
  );

  modport master (
    output rx_data, rx_valid, start,
    input  imem_we, imem_waddr, imem_wdata, busy, done, err, cpu_hold
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses a little-endian {count, words, checksum} byte stream from a UART
// and writes the words into instruction memory, holding the CPU in reset until it verifies.
`timescale 1ns/1ps
module imem_loader #(
  parameter int ADDR_W    = 14,
  parameter int BASE_ADDR = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_e;

  // Largest word count that still fits between BASE_ADDR and the top of memory.
  localparam logic [32:0] MAX_WORDS = (33'd1 << ADDR_W) - 33'(BASE_ADDR);

  state_e            state_q,    state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       shift_q,    shift_d;
  logic [31:0]       csum_q,     csum_d;
  logic [ADDR_W:0]   n_q,        n_d;
  logic [ADDR_W:0]   word_idx_q, word_idx_d;
  logic              we_q,       we_d;
  logic [ADDR_W-1:0] waddr_q,    waddr_d;
  logic [31:0]       wdata_q,    wdata_d;

  logic [31:0]       asm_word;
  logic              field_done;
  logic [ADDR_W:0]   addr_full;

  // Current byte dropped into its lane on top of the bytes already collected.
  always_comb begin
    asm_word = shift_q;
    unique case (byte_cnt_q)
      2'd0: asm_word[7:0]   = bus.rx_data;
      2'd1: asm_word[15:8]  = bus.rx_data;
      2'd2: asm_word[23:16] = bus.rx_data;
      2'd3: asm_word[31:24] = bus.rx_data;
      default: ;
    endcase
  end

  assign field_done = bus.rx_valid && (byte_cnt_q == 2'd3);
  assign addr_full  = (ADDR_W+1)'(BASE_ADDR) + word_idx_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_HDR;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      csum_q     <= '0;
      n_q        <= '0;
      word_idx_q <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      csum_q     <= csum_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  // NOTE: every next-state variable takes its hold value first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    csum_d     = csum_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;

    if (bus.start) begin
      // Restart wins over everything, including a byte arriving this cycle.
      state_d    = S_HDR;
      byte_cnt_d = '0;
      shift_d    = '0;
      csum_d     = '0;
      n_d        = '0;
      word_idx_d = '0;
    end else begin
      unique case (state_q)
        S_HDR: begin
          if (bus.rx_valid) begin
            shift_d    = asm_word;
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (field_done) begin
              if (asm_word == 32'd0) begin
                n_d     = '0;
                state_d = S_CHK;
              end else if ({1'b0, asm_word} > MAX_WORDS) begin
                state_d = S_ERR;
              end else begin
                n_d     = asm_word[ADDR_W:0];
                state_d = S_DATA;
              end
            end
          end
        end

        S_DATA: begin
          if (bus.rx_valid) begin
            shift_d    = asm_word;
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (field_done) begin
              we_d       = 1'b1;
              waddr_d    = addr_full[ADDR_W-1:0];
              wdata_d    = asm_word;
              csum_d     = csum_q + asm_word;
              word_idx_d = word_idx_q + 1'b1;
              if (word_idx_q + 1'b1 == n_q) begin
                state_d = S_CHK;
              end
            end
          end
        end

        S_CHK: begin
          if (bus.rx_valid) begin
            shift_d    = asm_word;
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (field_done) begin
              state_d = (asm_word == csum_q) ? S_DONE : S_ERR;
            end
          end
        end

        S_DONE, S_ERR: ;

        default: state_d = S_HDR;
      endcase
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.busy       = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
  assign bus.done       = (state_q == S_DONE);
  assign bus.err        = (state_q == S_ERR);
  assign bus.cpu_hold   = (state_q != S_DONE);

endmodule
